prbs_bist_ctrl: RTL and testbench

Built-in self-test controller for the PRBS link. One start request loads a seed and transmits a programmed number of PRBS-8 bits through a valid/ready handshake. In parallel it checks the looped-back receive stream against a local reference LFSR, counts bit errors and reports pass/fail. It sits between the test register block (start, seed, length) and the serial link under test (tx/rx bit streams).

---
 rtl/prbs_pkg.sv | 10 +
 rtl/prbs_lfsr8.sv | 18 +
 rtl/prbs_bist_ctrl.sv | 92 +++++++++
 tb/tb_prbs_bist_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared FSM states and PRBS-8 constants for the BIST controller
package prbs_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  localparam logic [7:0] PRBS_TAPS = 8'hB8;
  localparam logic [7:0] SEED_ZERO_SUB = 8'h01;
  localparam int PRBS_PERIOD = 255;
  function automatic logic [7:0] prbs_next(input logic [7:0] q);
    return {q[6:0], ^(q & PRBS_TAPS)};
  endfunction
endpackage

// File: rtl/prbs_lfsr8.sv
// prbs_lfsr8: loadable x^8+x^6+x^5+x^4+1 Fibonacci LFSR, load wins over advance
module prbs_lfsr8
  import prbs_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       advance,
  output logic [7:0] q,
  output logic       bit_out
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= SEED_ZERO_SUB;
    else if (load) q <= load_val;
    else if (advance) q <= prbs_next(q);
  assign bit_out = q[7];
endmodule

// File: rtl/prbs_bist_ctrl.sv
// prbs_bist_ctrl: PRBS-8 link BIST, transmits a seeded sequence and checks the loopback
module prbs_bist_ctrl
  import prbs_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       seed,
  input  logic [LEN_W-1:0] bit_count,
  output logic             tx_bit,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             rx_bit,
  input  logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [LEN_W-1:0] err_count
);
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  state_t state, state_n;
  logic [LEN_W-1:0] len_q, tx_cnt, rx_cnt;
  logic [DW-1:0] drain_cnt;
  logic [7:0] seed_eff, tx_q, ref_q;
  logic accept, aborted, tx_fire, tx_last, rx_fire, rx_complete, drain_exp, ref_bit;
  logic lfsr_unused;
  assign accept = start && (state == IDLE || state == DONE);
  assign busy = state == LOAD || state == RUN || state == DRAIN;
  assign tx_valid = state == RUN;
  assign tx_fire = tx_valid && tx_ready;
  assign tx_last = tx_fire && (tx_cnt + LEN_W'(1) == len_q);
  assign rx_fire = rx_valid && (state == RUN || state == DRAIN) && rx_cnt < len_q;
  assign rx_complete = rx_cnt == len_q || (rx_fire && rx_cnt + LEN_W'(1) == len_q);
  assign drain_exp = drain_cnt == DW'(DRAIN_TIMEOUT - 1);
  assign seed_eff = seed == 8'h00 ? SEED_ZERO_SUB : seed;
  assign pass = state == DONE && err_count == '0 && !timeout && !aborted;
  assign lfsr_unused = ^{tx_q, ref_q};
  prbs_lfsr8 u_tx (
    .clk(clk), .reset_n(reset_n), .load(accept), .load_val(seed_eff),
    .advance(tx_fire), .q(tx_q), .bit_out(tx_bit)
  );
  prbs_lfsr8 u_ref (
    .clk(clk), .reset_n(reset_n), .load(accept), .load_val(seed_eff),
    .advance(rx_fire), .q(ref_q), .bit_out(ref_bit)
  );
  // abort is checked first in every busy state so it beats same-cycle completions
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: state_n = accept ? LOAD : state;
      LOAD:       state_n = (abort || len_q == '0) ? DONE : RUN;
      RUN:        state_n = abort ? DONE : tx_last ? DRAIN : RUN;
      DRAIN:      state_n = (abort || rx_complete || drain_exp) ? DONE : DRAIN;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      done <= 1'b0;
      len_q <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      err_count <= '0;
      drain_cnt <= '0;
      timeout <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state <= state_n;
      done <= state_n == DONE && state != DONE;
      drain_cnt <= state == DRAIN ? drain_cnt + DW'(1) : '0;
      if (accept) begin
        len_q <= bit_count;
        tx_cnt <= '0;
        rx_cnt <= '0;
        err_count <= '0;
        timeout <= 1'b0;
        aborted <= 1'b0;
      end else begin
        if (tx_fire) tx_cnt <= tx_cnt + LEN_W'(1);
        if (rx_fire) rx_cnt <= rx_cnt + LEN_W'(1);
        if (rx_fire && rx_bit != ref_bit && err_count != '1) err_count <= err_count + LEN_W'(1);
        if (abort && busy) aborted <= 1'b1;
        if (state == DRAIN && !abort && !rx_complete && drain_exp) timeout <= 1'b1;
      end
    end
endmodule

// File: tb/tb_prbs_bist_ctrl.sv
// tb_prbs_bist_ctrl: directed scenario tests for the PRBS BIST controller
module tb_prbs_bist_ctrl;
  logic clk = 0, reset_n = 0, start = 0, abort = 0, tx_ready = 0, rx_bit = 0, rx_valid = 0;
  logic [7:0] seed = 0;
  logic [15:0] bit_count = 0;
  logic tx_bit, tx_valid, busy, done, pass, timeout;
  logic [15:0] err_count;
  int n_cmp = 0, n_bad = 0;
  logic txs [0:1023];
  int ntx_g, done_n, done_cyc, drain_cyc;
  bit saw_tx;

  always #5 clk = ~clk;

  prbs_bist_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .seed(seed),
    .bit_count(bit_count), .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_bit(rx_bit), .rx_valid(rx_valid), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count)
  );

  function automatic logic [7:0] ref_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  task automatic run_bist(input logic [7:0] sd, input logic [15:0] cnt, input int dly,
                          input bit toggle, input int rx_lim, input int i0, input int i1,
                          input int i2, input int max_cyc);
    logic [7:0] m;
    logic [63:0] pv, pb;
    logic hs, rv, rb;
    int nrx;
    bit finished;
    m = sd == 8'h00 ? 8'h01 : sd;
    pv = '0; pb = '0; nrx = 0; finished = 0;
    ntx_g = 0; done_n = 0; done_cyc = -1; drain_cyc = 0; saw_tx = 0;
    @(negedge clk);
    seed = sd; bit_count = cnt; start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < max_cyc && !finished; c++) begin
      if (done) begin
        finished = 1; done_n = 1; done_cyc = c;
      end else begin
        if (busy && !tx_valid && saw_tx) drain_cyc++;
        if (tx_valid) begin
          saw_tx = 1;
          n_cmp++;
          if (tx_bit !== m[7]) begin
            n_bad++;
            $display("FAIL tx_bit[%0d] got %b exp %b", ntx_g, tx_bit, m[7]);
          end
        end
        tx_ready = toggle ? c[0] : 1'b1;
        hs = tx_valid && tx_ready;
        if (hs) begin
          txs[ntx_g] = tx_bit;
          ntx_g++;
          m = ref_next(m);
        end
        pv = {pv[62:0], hs};
        pb = {pb[62:0], tx_bit};
        rv = pv[dly];
        rb = pb[dly];
        if (nrx >= rx_lim) rv = 0;
        if (rv) begin
          rb = rb ^ (nrx == i0 || nrx == i1 || nrx == i2);
          nrx++;
        end
        rx_valid = rv;
        rx_bit = rb;
        @(negedge clk);
      end
    end
    rx_valid = 0; tx_ready = 0;
    n_cmp++;
    if (!finished) begin
      n_bad++;
      $display("FAIL done_wait got no done within %0d cycles", max_cyc);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_n++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, pass, timeout, tx_valid, tx_bit, err_count} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h exp 0", {busy, done, pass, timeout, tx_valid, tx_bit, err_count});
    end
    reset_n = 1;
  endtask

  task automatic test_clean_loopback;
    logic [7:0] f8;
    run_bist(8'h01, 16'd16, 3, 0, 1000, -1, -1, -1, 300);
    f8 = {txs[0], txs[1], txs[2], txs[3], txs[4], txs[5], txs[6], txs[7]};
    n_cmp++; if (f8 !== 8'b0000_0001) begin n_bad++; $display("FAIL clean_first8 got %b exp 00000001", f8); end
    n_cmp++; if (ntx_g !== 16) begin n_bad++; $display("FAIL clean_ntx got %0d exp 16", ntx_g); end
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL clean_pass got %b exp 1", pass); end
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL clean_err got %0d exp 0", err_count); end
    n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL clean_done_pulses got %0d exp 1", done_n); end
  endtask

  task automatic test_backpressure;
    int diffs;
    run_bist(8'h5A, 16'd510, 0, 1, 1000, -1, -1, -1, 3000);
    diffs = 0;
    for (int i = 0; i < prbs_pkg::PRBS_PERIOD; i++) if (txs[i] !== txs[i + 255]) diffs++;
    n_cmp++; if (ntx_g !== 510) begin n_bad++; $display("FAIL bp_ntx got %0d exp 510", ntx_g); end
    n_cmp++; if (diffs !== 0) begin n_bad++; $display("FAIL bp_period got %0d diffs exp 0", diffs); end
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL bp_pass got %b exp 1", pass); end
  endtask

  task automatic test_error_injection;
    run_bist(8'h37, 16'd100, 0, 0, 1000, 10, 11, 57, 500);
    n_cmp++; if (err_count !== 16'd3) begin n_bad++; $display("FAIL inj_err got %0d exp 3", err_count); end
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL inj_pass got %b exp 0", pass); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL inj_timeout got %b exp 0", timeout); end
  endtask

  task automatic test_timeout;
    run_bist(8'h01, 16'd20, 0, 0, 15, -1, -1, -1, 300);
    n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL to_timeout got %b exp 1", timeout); end
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL to_pass got %b exp 0", pass); end
    n_cmp++; if (drain_cyc !== 64) begin n_bad++; $display("FAIL to_drain_cycles got %0d exp 64", drain_cyc); end
    n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL to_done_pulses got %0d exp 1", done_n); end
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL to_err got %0d exp 0", err_count); end
  endtask

  task automatic test_edge_cases;
    logic [7:0] f8;
    run_bist(8'h00, 16'd16, 0, 0, 1000, -1, -1, -1, 300);
    f8 = {txs[0], txs[1], txs[2], txs[3], txs[4], txs[5], txs[6], txs[7]};
    n_cmp++; if (f8 !== 8'b0000_0001) begin n_bad++; $display("FAIL seed0_first8 got %b exp 00000001", f8); end
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL seed0_pass got %b exp 1", pass); end
    run_bist(8'h42, 16'd0, 0, 0, 1000, -1, -1, -1, 50);
    n_cmp++; if (done_cyc !== 1) begin n_bad++; $display("FAIL len0_done_cycle got %0d exp 1", done_cyc); end
    n_cmp++; if (saw_tx !== 1'b0) begin n_bad++; $display("FAIL len0_tx_valid got %b exp 0", saw_tx); end
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL len0_pass got %b exp 1", pass); end
  endtask

  task automatic test_abort_and_reset;
    int n;
    @(negedge clk);
    seed = 8'h01; bit_count = 16'd100; start = 1; tx_ready = 1;
    @(negedge clk);
    start = 0; n = 0;
    for (int c = 0; c < 50 && n < 5; c++) begin
      if (tx_valid) n++;
      rx_valid = tx_valid; rx_bit = tx_bit;
      @(negedge clk);
    end
    abort = 1; tx_ready = 0; rx_valid = 0;
    n_cmp++; if (tx_valid !== 1'b1) begin n_bad++; $display("FAIL abort_pre_valid got %b exp 1", tx_valid); end
    @(negedge clk);
    abort = 0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL abort_tx_valid got %b exp 0", tx_valid); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL abort_done got %b exp 1", done); end
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL abort_pass got %b exp 0", pass); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b exp 0", busy); end
    run_bist(8'hA5, 16'd30, 1, 0, 1000, -1, -1, -1, 300);
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL rearm_pass got %b exp 1", pass); end
    n_cmp++; if (ntx_g !== 30) begin n_bad++; $display("FAIL rearm_ntx got %0d exp 30", ntx_g); end
    @(negedge clk);
    seed = 8'h01; bit_count = 16'd100; start = 1; tx_ready = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rx_valid = 1; rx_bit = 1;
    @(negedge clk);
    rx_valid = 0; rx_bit = 0;
    n_cmp++; if (err_count !== 16'd1) begin n_bad++; $display("FAIL pre_reset_err got %0d exp 1", err_count); end
    reset_n = 0;
    #1;
    n_cmp++;
    if ({busy, done, pass, timeout, tx_valid, tx_bit, err_count} !== 22'd0) begin
      n_bad++;
      $display("FAIL midrun_reset got %h exp 0", {busy, done, pass, timeout, tx_valid, tx_bit, err_count});
    end
    tx_ready = 0;
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_no_done got %b exp 0", done); end
    reset_n = 1;
  endtask

  initial begin
    test_reset();
    test_clean_loopback();
    test_backpressure();
    test_error_injection();
    test_timeout();
    test_edge_cases();
    test_abort_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
